// File: rtl/lcd_char_driver_if.sv
// ---------------------------------------------------------------------------
// lcd_char_driver_if
//   Bundles the text-generator inputs and the LCD pin outputs of
//   lcd_char_driver into a single interface.
//
//   Signals
//     line_1, line_2 [127:0]  row text, char i at line[127-8i -: 8]
//     lcd_e                   LCD enable strobe
//     lcd_rs                  0 = command, 1 = data
//     lcd_rw                  always 0 (write only)
//     lcd_data [7:0]          LCD data bus
//     init_done               high once the init sequence is complete
//     frame_done              1-cycle pulse at the end of each full refresh
//
//   Modports
//     master : the driver (consumes text, drives the LCD pins)
//     slave  : the text source / LCD side
// ---------------------------------------------------------------------------
interface lcd_char_driver_if;
    logic [127:0] line_1;
    logic [127:0] line_2;
    logic         lcd_e;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data;
    logic         init_done;
    logic         frame_done;

    modport master (
        input  line_1, line_2,
        output lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done
    );

    modport slave (
        output line_1, line_2,
        input  lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done
    );
endinterface

// File: rtl/lcd_char_driver.sv
// ---------------------------------------------------------------------------
// lcd_char_driver
//   Drives an HD44780-compatible 16x2 character LCD in 8-bit write-only mode.
//   After a power-on delay it sends the init commands once, then refreshes
//   both rows forever: 0x80, 16 row-0 chars, 0xC0, 16 row-1 chars.
//   Each byte is a SETUP / E_HIGH / WAIT transaction; the WAIT phase after a
//   clear-display command is stretched to CLEAR_CYC.
//
//   Ports
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     bus    lcd_char_driver_if.master (text in, LCD pins + status out)
// ---------------------------------------------------------------------------
module lcd_char_driver #(
    parameter int POWERON_CYC = 750000,
    parameter int SETUP_CYC   = 2,
    parameter int E_CYC       = 12,
    parameter int CMD_CYC     = 2500,
    parameter int CLEAR_CYC   = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_char_driver_if.master   bus
);

    localparam int MAX_A   = (POWERON_CYC > CLEAR_CYC) ? POWERON_CYC : CLEAR_CYC;
    localparam int MAX_B   = (CMD_CYC > E_CYC) ? CMD_CYC : E_CYC;
    localparam int MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        S_PWR_WAIT = 3'd0,
        S_INIT     = 3'd1,
        S_L1_ADDR  = 3'd2,
        S_L1_CHR   = 3'd3,
        S_L2_ADDR  = 3'd4,
        S_L2_CHR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP  = 2'd0,
        PH_E_HIGH = 2'd1,
        PH_WAIT   = 2'd2
    } phase_t;

    state_t          r_state;
    phase_t          r_phase;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_idx;
    logic [127:0]    r_line1_sh;
    logic [127:0]    r_line2_sh;
    logic            r_lcd_e;
    logic            r_lcd_rs;
    logic [7:0]      r_lcd_data;
    logic            r_init_done;
    logic            r_frame_done;

    state_t          w_state_nxt;
    phase_t          w_phase_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [3:0]      w_idx_nxt;
    logic            w_frame_pulse;
    logic [CW-1:0]   w_len;
    logic            w_last;
    logic            w_e_nxt;
    logic            w_rs_nxt;
    logic [7:0]      w_byte_nxt;
    logic            w_capture;

    // Init command table, issued in index order 0..3.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] v;
        case (idx)
            2'd0:    v = 8'h38;
            2'd1:    v = 8'h0C;
            2'd2:    v = 8'h06;
            default: v = 8'h01;
        endcase
        return v;
    endfunction

    // Char idx of a row: char 0 is the top byte, so byte lane = 15 - idx.
    function automatic logic [7:0] char_of(input logic [127:0] line, input logic [3:0] idx);
        logic [3:0] lane;
        lane = 4'd15 - idx;
        return line[{lane, 3'b000} +: 8];
    endfunction

    // Length of the current phase; the wait after a clear command is longer.
    always_comb begin
        w_len = CW'(CMD_CYC);
        if (r_state == S_PWR_WAIT) begin
            w_len = CW'(POWERON_CYC);
        end else begin
            case (r_phase)
                PH_SETUP:  w_len = CW'(SETUP_CYC);
                PH_E_HIGH: w_len = CW'(E_CYC);
                PH_WAIT:   w_len = ((r_lcd_rs == 1'b0) && (r_lcd_data == 8'h01))
                                   ? CW'(CLEAR_CYC) : CW'(CMD_CYC);
                default:   w_len = CW'(CMD_CYC);
            endcase
        end
    end

    assign w_last = (r_cnt == (w_len - CW'(1)));

    // Shadows load at the end of the first setup cycle of every 0x80 write.
    assign w_capture = (r_state == S_L1_ADDR) && (r_phase == PH_SETUP) && (r_cnt == '0);

    // Next-state logic for the top sequence and the per-byte phase.
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_cnt_nxt     = r_cnt + CW'(1);
        w_idx_nxt     = r_idx;
        w_frame_pulse = 1'b0;
        if (r_state == S_PWR_WAIT) begin
            if (w_last) begin
                w_state_nxt = S_INIT;
                w_phase_nxt = PH_SETUP;
                w_cnt_nxt   = '0;
                w_idx_nxt   = 4'd0;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end else if (w_last) begin
            w_cnt_nxt = '0;
            case (r_phase)
                PH_SETUP:  w_phase_nxt = PH_E_HIGH;
                PH_E_HIGH: w_phase_nxt = PH_WAIT;
                PH_WAIT: begin
                    w_phase_nxt = PH_SETUP;
                    case (r_state)
                        S_INIT: begin
                            if (r_idx == 4'd3) begin
                                w_state_nxt = S_L1_ADDR;
                                w_idx_nxt   = 4'd0;
                            end else begin
                                w_idx_nxt = r_idx + 4'd1;
                            end
                        end
                        S_L1_ADDR: w_state_nxt = S_L1_CHR;
                        S_L1_CHR: begin
                            // 4-bit index wraps to 0 as the row completes.
                            w_idx_nxt = r_idx + 4'd1;
                            if (r_idx == 4'd15) begin
                                w_state_nxt = S_L2_ADDR;
                            end else begin
                                w_state_nxt = S_L1_CHR;
                            end
                        end
                        S_L2_ADDR: w_state_nxt = S_L2_CHR;
                        S_L2_CHR: begin
                            w_idx_nxt = r_idx + 4'd1;
                            if (r_idx == 4'd15) begin
                                w_state_nxt   = S_L1_ADDR;
                                w_frame_pulse = 1'b1;
                            end else begin
                                w_state_nxt = S_L2_CHR;
                            end
                        end
                        default: begin
                            // Unreachable encoding: restart from power-on.
                            w_state_nxt = S_PWR_WAIT;
                            w_idx_nxt   = 4'd0;
                        end
                    endcase
                end
                default: w_phase_nxt = PH_SETUP;
            endcase
        end else begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    // Pin values for the next cycle, decoded from the next state so the
    // outputs can be registered without adding latency.
    always_comb begin
        w_e_nxt    = 1'b0;
        w_rs_nxt   = 1'b0;
        w_byte_nxt = 8'h00;
        if (w_state_nxt == S_PWR_WAIT) begin
            w_e_nxt = 1'b0;
        end else begin
            w_e_nxt = (w_phase_nxt == PH_E_HIGH);
            case (w_state_nxt)
                S_INIT:    w_byte_nxt = init_cmd(w_idx_nxt[1:0]);
                S_L1_ADDR: w_byte_nxt = 8'h80;
                S_L1_CHR: begin
                    w_rs_nxt   = 1'b1;
                    w_byte_nxt = char_of(r_line1_sh, w_idx_nxt);
                end
                S_L2_ADDR: w_byte_nxt = 8'hC0;
                S_L2_CHR: begin
                    w_rs_nxt   = 1'b1;
                    w_byte_nxt = char_of(r_line2_sh, w_idx_nxt);
                end
                default:   w_byte_nxt = 8'h00;
            endcase
        end
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_PWR_WAIT;
            r_phase      <= PH_SETUP;
            r_cnt        <= '0;
            r_idx        <= 4'd0;
            r_lcd_e      <= 1'b0;
            r_lcd_rs     <= 1'b0;
            r_lcd_data   <= 8'h00;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_lcd_e      <= w_e_nxt;
            r_lcd_rs     <= w_rs_nxt;
            r_lcd_data   <= w_byte_nxt;
            r_init_done  <= r_init_done | (w_state_nxt == S_L1_ADDR);
            r_frame_done <= w_frame_pulse;
        end
    end

    // Text shadow registers, refreshed once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line1_sh <= 128'h0;
            r_line2_sh <= 128'h0;
        end else if (w_capture) begin
            r_line1_sh <= bus.line_1;
            r_line2_sh <= bus.line_2;
        end else begin
            r_line1_sh <= r_line1_sh;
            r_line2_sh <= r_line2_sh;
        end
    end

    assign bus.lcd_e      = r_lcd_e;
    assign bus.lcd_rs     = r_lcd_rs;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_data   = r_lcd_data;
    assign bus.init_done  = r_init_done;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_char_driver.sv
// ---------------------------------------------------------------------------
// tb_lcd_char_driver
//   Self-checking bench for lcd_char_driver with short timing parameters.
//   Expected LCD writes (rs, byte, E-low gap before the write, init_done)
//   are queued as each scenario is set up and compared as the DUT emits them.
// ---------------------------------------------------------------------------
module tb_lcd_char_driver;

    localparam int P_PWR   = 20;
    localparam int P_SETUP = 2;
    localparam int P_E     = 3;
    localparam int P_CMD   = 4;
    localparam int P_CLR   = 10;
    localparam int GAP_N   = P_CMD + P_SETUP;     // E fall to next E rise
    localparam int GAP_CLR = P_CLR + P_SETUP;     // after clear command
    localparam int GAP_RST = P_PWR + P_SETUP;     // reset release to first E rise
    localparam int FRAME   = 34 * (P_SETUP + P_E + P_CMD);

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         gap;
        logic       idone;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_char_driver_if bus ();

    lcd_char_driver #(
        .POWERON_CYC (P_PWR),
        .SETUP_CYC   (P_SETUP),
        .E_CYC       (P_E),
        .CMD_CYC     (P_CMD),
        .CLEAR_CYC   (P_CLR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_fall = 0;
    logic prev_e = 1'b0;
    logic prev_fd = 1'b0;
    int   fd_wide = 0;
    int   fd_q[$];
    wr_t  sb[$];

    logic [7:0] game_b [16] = '{8'h20, 8'h20, 8'h20, 8'h47, 8'h61, 8'h6D, 8'h65, 8'h20,
                                8'h53, 8'h74, 8'h61, 8'h72, 8'h74, 8'h20, 8'h20, 8'h20};
    logic [7:0] succ_b [16] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h53, 8'h75, 8'h63, 8'h63,
                                8'h65, 8'h73, 8'h73, 8'h21, 8'h20, 8'h20, 8'h20, 8'h20};

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Tracks E falling edges and frame_done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_fall <= cyc;
            prev_e    <= 1'b0;
            prev_fd   <= 1'b0;
        end else begin
            if (prev_e && !bus.lcd_e) last_fall <= cyc;
            prev_e <= bus.lcd_e;
            if (bus.frame_done === 1'b1) begin
                fd_q.push_back(cyc);
                if (prev_fd) fd_wide <= fd_wide + 1;
            end
            prev_fd <= bus.frame_done;
        end
    end

    task automatic push(input logic rs, input logic [7:0] d, input int gap, input logic idone);
        wr_t w;
        w.rs = rs; w.d = d; w.gap = gap; w.idone = idone;
        sb.push_back(w);
    endtask

    task automatic push_frame(input logic [7:0] r0 [16], input logic [7:0] r1 [16], input int gap0);
        push(1'b0, 8'h80, gap0, 1'b1);
        for (int i = 0; i < 16; i++) push(1'b1, r0[i], GAP_N, 1'b1);
        push(1'b0, 8'hC0, GAP_N, 1'b1);
        for (int i = 0; i < 16; i++) push(1'b1, r1[i], GAP_N, 1'b1);
    endtask

    // Captures the next E pulse: rs/data/init_done at rise, E width, gap since last fall.
    task automatic get_write(output logic rs, output logic [7:0] d, output logic idone,
                             output int ew, output int gap, output bit to);
        int n;
        int rise;
        to = 1'b0; rs = 1'b0; d = 8'h00; idone = 1'b0; ew = 0; gap = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.lcd_e !== 1'b1 && n < 3000);
        if (bus.lcd_e !== 1'b1) begin
            to = 1'b1;
            return;
        end
        rise  = cyc;
        gap   = rise - last_fall;
        rs    = bus.lcd_rs;
        d     = bus.lcd_data;
        idone = bus.init_done;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.lcd_e === 1'b1 && n < 200);
        if (bus.lcd_e === 1'b1) to = 1'b1;
        ew = cyc - rise;
    endtask

    task automatic test_reset();
        int bad;
        bus.line_1 = "   Game Start   ";
        bus.line_2 = {16{8'h20}};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.init_done, bus.frame_done} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got e=%0b rs=%0b rw=%0b data=%02h init=%0b frame=%0b, want all 0",
                     bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.init_done, bus.frame_done);
        end
        #1 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < P_PWR - 1; i++) begin
            @(negedge clk);
            if ({bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.init_done} !== 12'h0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL poweron_idle: got %0d non-idle cycles, want 0", bad);
        end
    endtask

    task automatic test_init();
        wr_t e; logic rs; logic [7:0] d; logic id; int ew; int gp; bit to;
        push(1'b0, 8'h38, GAP_RST, 1'b0);
        push(1'b0, 8'h0C, GAP_N,   1'b0);
        push(1'b0, 8'h06, GAP_N,   1'b0);
        push(1'b0, 8'h01, GAP_N,   1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_write(rs, d, id, ew, gp, to);
            checks++;
            if (to || {rs, d, id} !== {e.rs, e.d, e.idone} || ew !== P_E || gp !== e.gap) begin
                errors++;
                $display("FAIL init_write: got rs=%0b data=%02h init=%0b e_w=%0d gap=%0d to=%0b, want rs=%0b data=%02h init=%0b e_w=%0d gap=%0d",
                         rs, d, id, ew, gp, to, e.rs, e.d, e.idone, P_E, e.gap);
            end
        end
    endtask

    task automatic test_frame();
        wr_t e; logic rs; logic [7:0] d; logic id; int ew; int gp; bit to;
        logic [7:0] sp [16];
        for (int i = 0; i < 16; i++) sp[i] = 8'h20;
        push_frame(game_b, sp, GAP_CLR);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_write(rs, d, id, ew, gp, to);
            checks++;
            if (to || {rs, d, id} !== {e.rs, e.d, e.idone} || ew !== P_E || gp !== e.gap) begin
                errors++;
                $display("FAIL frame_write: got rs=%0b data=%02h init=%0b e_w=%0d gap=%0d to=%0b, want rs=%0b data=%02h init=%0b e_w=%0d gap=%0d",
                         rs, d, id, ew, gp, to, e.rs, e.d, e.idone, P_E, e.gap);
            end
        end
    endtask

    task automatic test_shadow();
        wr_t e; logic rs; logic [7:0] d; logic id; int ew; int gp; bit to;
        int k;
        logic [7:0] sp [16];
        for (int i = 0; i < 16; i++) sp[i] = 8'h20;
        push_frame(game_b, sp, GAP_N);
        push_frame(succ_b, sp, GAP_N);
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_write(rs, d, id, ew, gp, to);
            // Change the text while row-0 char 5 is still in its wait phase.
            if (k == 6) bus.line_1 = "    Success!    ";
            k++;
            checks++;
            if (to || {rs, d, id} !== {e.rs, e.d, e.idone} || ew !== P_E || gp !== e.gap) begin
                errors++;
                $display("FAIL shadow_write[%0d]: got rs=%0b data=%02h init=%0b e_w=%0d gap=%0d to=%0b, want rs=%0b data=%02h init=%0b e_w=%0d gap=%0d",
                         k - 1, rs, d, id, ew, gp, to, e.rs, e.d, e.idone, P_E, e.gap);
            end
        end
    endtask

    task automatic test_frame_period();
        int start;
        int n;
        int bad;
        start = fd_q.size();
        n = 0;
        bad = 0;
        while (fd_q.size() < start + 3 && n < 2000) begin
            @(negedge clk);
            n++;
            if (bus.init_done !== 1'b1) bad++;
        end
        checks++;
        if (fd_q.size() < start + 3) begin
            errors++;
            $display("FAIL frame_done_count: got %0d pulses, want 3", fd_q.size() - start);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (fd_q[start + i + 1] - fd_q[start + i] !== FRAME) begin
                    errors++;
                    $display("FAIL frame_period: got %0d cycles, want %0d",
                             fd_q[start + i + 1] - fd_q[start + i], FRAME);
                end
            end
        end
        checks++;
        if (bad !== 0 || fd_wide !== 0) begin
            errors++;
            $display("FAIL free_run_flags: got init_low=%0d wide_frame_done=%0d, want 0 and 0", bad, fd_wide);
        end
    endtask

    task automatic test_reset_mid();
        wr_t e; logic rs; logic [7:0] d; logic id; int ew; int gp; bit to;
        int n;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(bus.lcd_e === 1'b1 && bus.lcd_rs === 1'b1) && n < 1000);
        checks++;
        if (!(bus.lcd_e === 1'b1 && bus.lcd_rs === 1'b1)) begin
            errors++;
            $display("FAIL mid_reset_find: got e=%0b rs=%0b, want 1 and 1", bus.lcd_e, bus.lcd_rs);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.lcd_e, bus.lcd_rs, bus.lcd_data, bus.init_done, bus.frame_done} !== 12'h0) begin
            errors++;
            $display("FAIL mid_reset_async: got e=%0b rs=%0b data=%02h init=%0b frame=%0b, want all 0",
                     bus.lcd_e, bus.lcd_rs, bus.lcd_data, bus.init_done, bus.frame_done);
        end
        bus.line_2 = {8'h00, {15{8'h20}}};
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        push(1'b0, 8'h38, GAP_RST, 1'b0);
        push(1'b0, 8'h0C, GAP_N,   1'b0);
        push(1'b0, 8'h06, GAP_N,   1'b0);
        push(1'b0, 8'h01, GAP_N,   1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_write(rs, d, id, ew, gp, to);
            checks++;
            if (to || {rs, d, id} !== {e.rs, e.d, e.idone} || ew !== P_E || gp !== e.gap) begin
                errors++;
                $display("FAIL reinit_write: got rs=%0b data=%02h init=%0b e_w=%0d gap=%0d to=%0b, want rs=%0b data=%02h init=%0b e_w=%0d gap=%0d",
                         rs, d, id, ew, gp, to, e.rs, e.d, e.idone, P_E, e.gap);
            end
        end
    endtask

    task automatic test_nonprintable();
        wr_t e; logic rs; logic [7:0] d; logic id; int ew; int gp; bit to;
        logic [7:0] r1 [16];
        for (int i = 0; i < 16; i++) r1[i] = 8'h20;
        r1[0] = 8'h00;
        push_frame(succ_b, r1, GAP_CLR);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_write(rs, d, id, ew, gp, to);
            checks++;
            if (to || {rs, d, id} !== {e.rs, e.d, e.idone} || ew !== P_E || gp !== e.gap) begin
                errors++;
                $display("FAIL nonprint_write: got rs=%0b data=%02h init=%0b e_w=%0d gap=%0d to=%0b, want rs=%0b data=%02h init=%0b e_w=%0d gap=%0d",
                         rs, d, id, ew, gp, to, e.rs, e.d, e.idone, P_E, e.gap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_frame();
        test_shadow();
        test_frame_period();
        test_reset_mid();
        test_nonprintable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
